// File: rtl/nfu_pkg.sv
// Shared definitions for the NFU-2 tile sequencer: FSM state codes, tree op
// codes, partial-sum source codes and a saturating increment helper.
package nfu_pkg;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Tree operation select
    localparam logic OP_SUM = 1'b0;
    localparam logic OP_MAX = 1'b1;

    // NFU-2 partial-sum source select
    localparam logic [1:0] PSUM_ZERO  = 2'd0;
    localparam logic [1:0] PSUM_NBOUT = 2'd1;
    localparam logic [1:0] PSUM_FWD   = 2'd2;

    // Width of the optional performance counters
    localparam int PERF_W = 32;

    // Increment that holds at all-ones instead of wrapping
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nfu2_tile_counter.sv
// Nested input-tile / output-tile counter. ii runs 0..ni; when it wraps, oi
// advances. Both return to 0 after the final (oi==no, ii==ni) step so the
// read address rests at 0 between commands.
module nfu2_tile_counter
    import nfu_pkg::*;
#(
    parameter int TILE_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [TILE_W-1:0] i_ni,
    input  logic [TILE_W-1:0] i_no,
    output logic [TILE_W-1:0] o_ii,
    output logic [TILE_W-1:0] o_oi,
    output logic              o_ii_last,
    output logic              o_all_last
);

    logic [TILE_W-1:0] r_ii;
    logic [TILE_W-1:0] r_oi;
    logic              w_ii_last;
    logic              w_oi_last;

    assign w_ii_last  = (r_ii == i_ni);
    assign w_oi_last  = (r_oi == i_no);
    assign o_ii       = r_ii;
    assign o_oi       = r_oi;
    assign o_ii_last  = w_ii_last;
    assign o_all_last = w_ii_last && w_oi_last;

    // Advance ii on every step, carrying into oi when ii reaches ni
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_ii <= '0;
            r_oi <= '0;
        end else if (i_step) begin
            if (w_ii_last) begin
                r_ii <= '0;
                r_oi <= w_oi_last ? '0 : r_oi + 1'b1;
            end else begin
                r_ii <= r_ii + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nfu2_tile_sequencer.sv
// NFU-2 tile sequencer: walks (output tile, input tile) pairs one NFU-1 beat
// at a time, drives NBout read/write and the NFU-2 partial-sum source, and
// forwards the previous stage-2 result on back-to-back beats of one tile.
// Optional build macro: NFU2_SEQ_PERF_EN adds o_perf_busy / o_perf_stall.
module nfu2_tile_sequencer
    import nfu_pkg::*;
#(
    parameter int N      = 16,
    parameter int N_OPS  = 1,
    parameter int TILE_W = 8,
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [TILE_W-1:0] i_cmd_ni,
    input  logic [TILE_W-1:0] i_cmd_no,
    input  logic [N_OPS-1:0]  i_cmd_op,
    input  logic              i_beat_valid,
    output logic              o_beat_ready,
    output logic [N_OPS-1:0]  o_op,
    output logic              o_nbout_rd_en,
    output logic [ADDR_W-1:0] o_nbout_rd_addr,
    output logic [1:0]        o_psum_sel,
    output logic              o_nbout_wr_en,
    output logic [ADDR_W-1:0] o_nbout_wr_addr,
    output logic              o_last,
`ifdef NFU2_SEQ_PERF_EN
    output logic [31:0]       o_perf_busy,
    output logic [31:0]       o_perf_stall,
`endif
    output logic              o_done
);

    // The datapath word must fit the 32-bit performance counter path
    if (N < 1 || N > PERF_W) begin : g_bad_width
        $error("nfu2_tile_sequencer: N must be in 1..32");
    end

    logic [1:0]        r_state;
    logic [TILE_W-1:0] r_ni;
    logic [TILE_W-1:0] r_no;
    logic [N_OPS-1:0]  r_op;
    logic              r_done;

    logic              r_s2_vld;
    logic              r_s2_last;
    logic [TILE_W-1:0] r_s2_oi;
    logic [1:0]        r_s2_psel;

    logic              w_cmd_acc;
    logic              w_beat_rdy;
    logic              w_beat_acc;
    logic [TILE_W-1:0] w_ii;
    logic [TILE_W-1:0] w_oi;
    logic              w_ii_last;
    logic              w_all_last;
    logic              w_fwd_hit;
    logic [1:0]        w_psel;

    assign w_cmd_acc  = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_beat_rdy = (r_state == ST_RUN) && !rst;
    assign w_beat_acc = w_beat_rdy && i_beat_valid;

    // A beat of the same output tile sitting in stage 2 right now means the
    // tree result is not yet in NBout: take it from the forward path instead.
    assign w_fwd_hit  = r_s2_vld && (r_s2_oi == w_oi);
    assign w_psel     = (w_ii == '0) ? PSUM_ZERO :
                        (w_fwd_hit   ? PSUM_FWD : PSUM_NBOUT);

    nfu2_tile_counter #(
        .TILE_W     (TILE_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cmd_acc),
        .i_step     (w_beat_acc),
        .i_ni       (r_ni),
        .i_no       (r_no),
        .o_ii       (w_ii),
        .o_oi       (w_oi),
        .o_ii_last  (w_ii_last),
        .o_all_last (w_all_last)
    );

    // Command FSM: IDLE -> RUN on accept, RUN -> DRAIN after the final beat,
    // DRAIN lets the last stage-2 write retire and raises done next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_state <= ST_RUN;
                        r_op    <= i_cmd_op;
                    end
                end
                ST_RUN: begin
                    if (w_beat_acc && w_all_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tile limits are held for the whole command
    always_ff @(posedge clk) begin
        if (w_cmd_acc) begin
            r_ni <= i_cmd_ni;
            r_no <= i_cmd_no;
        end
    end

    // Stage-2 valid: set by every accepted beat, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= w_beat_acc;
        end
    end

    // Stage-2 beat attributes captured at stage 1
    always_ff @(posedge clk) begin
        if (w_beat_acc) begin
            r_s2_oi   <= w_oi;
            r_s2_last <= w_ii_last;
            r_s2_psel <= w_psel;
        end
    end

    assign o_cmd_ready     = (r_state == ST_IDLE);
    assign o_beat_ready    = w_beat_rdy;
    assign o_op            = r_op;
    assign o_nbout_rd_en   = w_beat_acc && (w_ii != '0) && !w_fwd_hit;
    assign o_nbout_rd_addr = ADDR_W'(w_oi);
    // A write still in stage 2 when reset arrives is suppressed
    assign o_nbout_wr_en   = r_s2_vld && !rst;
    assign o_nbout_wr_addr = r_s2_vld ? ADDR_W'(r_s2_oi) : '0;
    assign o_last          = r_s2_vld && r_s2_last && !rst;
    assign o_psum_sel      = r_s2_vld ? r_s2_psel : PSUM_ZERO;
    assign o_done          = r_done;

`ifdef NFU2_SEQ_PERF_EN
    logic [PERF_W-1:0] r_perf_busy;
    logic [PERF_W-1:0] r_perf_stall;

    // Busy counts RUN/DRAIN cycles, stall counts RUN cycles without a beat
    always_ff @(posedge clk) begin
        if (rst || w_cmd_acc) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_state == ST_RUN || r_state == ST_DRAIN) begin
                r_perf_busy <= sat_inc(r_perf_busy);
            end
            if (r_state == ST_RUN && !i_beat_valid) begin
                r_perf_stall <= sat_inc(r_perf_stall);
            end
        end
    end

    assign o_perf_busy  = r_perf_busy;
    assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_nfu2_tile_sequencer.sv
// Bench for nfu2_tile_sequencer: table of commands plus hand-written
// sequences for reset mid-command, held command valid and perf counters.
module tb_nfu2_tile_sequencer;

    localparam int N      = 16;
    localparam int N_OPS  = 1;
    localparam int TILE_W = 8;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [TILE_W-1:0] i_cmd_ni;
    logic [TILE_W-1:0] i_cmd_no;
    logic [N_OPS-1:0]  i_cmd_op;
    logic              i_beat_valid;
    logic              o_beat_ready;
    logic [N_OPS-1:0]  o_op;
    logic              o_nbout_rd_en;
    logic [ADDR_W-1:0] o_nbout_rd_addr;
    logic [1:0]        o_psum_sel;
    logic              o_nbout_wr_en;
    logic [ADDR_W-1:0] o_nbout_wr_addr;
    logic              o_last;
    logic              o_done;
`ifdef NFU2_SEQ_PERF_EN
    logic [31:0]       o_perf_busy;
    logic [31:0]       o_perf_stall;
`endif

    nfu2_tile_sequencer #(
        .N               (N),
        .N_OPS           (N_OPS),
        .TILE_W          (TILE_W),
        .ADDR_W          (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_ni        (i_cmd_ni),
        .i_cmd_no        (i_cmd_no),
        .i_cmd_op        (i_cmd_op),
        .i_beat_valid    (i_beat_valid),
        .o_beat_ready    (o_beat_ready),
        .o_op            (o_op),
        .o_nbout_rd_en   (o_nbout_rd_en),
        .o_nbout_rd_addr (o_nbout_rd_addr),
        .o_psum_sel      (o_psum_sel),
        .o_nbout_wr_en   (o_nbout_wr_en),
        .o_nbout_wr_addr (o_nbout_wr_addr),
        .o_last          (o_last),
`ifdef NFU2_SEQ_PERF_EN
        .o_perf_busy     (o_perf_busy),
        .o_perf_stall    (o_perf_stall),
`endif
        .o_done          (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int last;
        int psel;
        int op;
    } wr_t;

    typedef struct {
        int ni;
        int no;
        int op;
        int gap;
        int exp_wr;
        int exp_rd;
        int exp_last;
    } vec_t;

    wr_t  sb[$];
    wr_t  mon_e;
    vec_t tbl[6];

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_rd    = 0;
    int n_last  = 0;

    // Reference model of the tile walk
    int m_ni, m_no, m_op, m_ii, m_oi, m_prev_cyc, m_prev_oi;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write monitor: every NBout write is matched against the scoreboard
    always @(negedge clk) begin
        if (o_nbout_wr_en) begin
            n_wr++;
            if (o_last) n_last++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got write to addr %0d, required no write (cycle %0d)",
                         o_nbout_wr_addr, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr",  int'(o_nbout_wr_addr), mon_e.addr);
                chk("wr_last",  int'(o_last),          mon_e.last);
                chk("psum_sel", int'(o_psum_sel),      mon_e.psel);
                chk("op",       int'(o_op),            mon_e.op);
            end
        end else if (o_last) begin
            chk("last_without_wr", int'(o_last), 0);
        end
        if (o_nbout_rd_en) n_rd++;
    end

    task automatic arm_model(input int ni, input int no, input int op);
        m_ni = ni; m_no = no; m_op = op;
        m_ii = 0;  m_oi = 0;
        m_prev_cyc = -10; m_prev_oi = 0;
        n_wr = 0; n_rd = 0; n_last = 0;
    endtask

    // Present a command at posedge+1; returns at posedge+1 of the first RUN cycle
    task automatic start_cmd(input int ni, input int no, input int op, input bit hold);
        i_cmd_valid = 1'b1;
        i_cmd_ni    = TILE_W'(ni);
        i_cmd_no    = TILE_W'(no);
        i_cmd_op    = N_OPS'(op);
        @(negedge clk);
        chk("cmd_ready_idle", int'(o_cmd_ready), 1);
        @(posedge clk); #1;
        if (!hold) i_cmd_valid = 1'b0;
        arm_model(ni, no, op);
    endtask

    task automatic drive_beat();
        bit hit;
        int exp_rd, psel, last;
        hit    = (m_prev_cyc == cyc - 1) && (m_prev_oi == m_oi);
        exp_rd = (m_ii > 0 && !hit) ? 1 : 0;
        psel   = (m_ii == 0) ? 0 : (hit ? 2 : 1);
        last   = (m_ii == m_ni) ? 1 : 0;
        i_beat_valid = 1'b1;
        @(negedge clk);
        chk("beat_ready",     int'(o_beat_ready),    1);
        chk("cmd_ready_busy", int'(o_cmd_ready),     0);
        chk("rd_en",          int'(o_nbout_rd_en),   exp_rd);
        chk("rd_addr",        int'(o_nbout_rd_addr), m_oi);
        sb.push_back('{m_oi, last, psel, m_op});
        m_prev_cyc = cyc;
        m_prev_oi  = m_oi;
        if (m_ii == m_ni) begin
            m_ii = 0;
            m_oi++;
        end else begin
            m_ii++;
        end
        @(posedge clk); #1;
        i_beat_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        i_beat_valid = 1'b0;
        @(negedge clk);
        chk("stall_beat_ready", int'(o_beat_ready),  1);
        chk("stall_rd_en",      int'(o_nbout_rd_en), 0);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1 of the cycle after the final beat
    task automatic finish_cmd(input int exp_wr, input int exp_rd, input int exp_last);
        @(negedge clk);
        chk("done_early",      int'(o_done),      0);
        chk("drain_cmd_ready", int'(o_cmd_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done",            int'(o_done),      1);
        chk("done_cmd_ready",  int'(o_cmd_ready), 1);
        chk("n_writes",        n_wr,              exp_wr);
        chk("n_reads",         n_rd,              exp_rd);
        chk("n_last",          n_last,            exp_last);
        chk("sb_drained",      sb.size(),         0);
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_idle();
        chk("idle_cmd_ready", int'(o_cmd_ready),     1);
        chk("idle_beat_rdy",  int'(o_beat_ready),    0);
        chk("idle_op",        int'(o_op),            0);
        chk("idle_rd_en",     int'(o_nbout_rd_en),   0);
        chk("idle_rd_addr",   int'(o_nbout_rd_addr), 0);
        chk("idle_psum_sel",  int'(o_psum_sel),      0);
        chk("idle_wr_en",     int'(o_nbout_wr_en),   0);
        chk("idle_wr_addr",   int'(o_nbout_wr_addr), 0);
        chk("idle_last",      int'(o_last),          0);
        chk("idle_done",      int'(o_done),          0);
    endtask

    task automatic run_vec(input vec_t v);
        start_cmd(v.ni, v.no, v.op, 1'b0);
        for (int b = 0; b < (v.ni + 1) * (v.no + 1); b++) begin
            if (b > 0) begin
                for (int g = 0; g < v.gap; g++) idle_cycle();
            end
            drive_beat();
        end
        finish_cmd(v.exp_wr, v.exp_rd, v.exp_last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ni no op gap  wr rd last
        tbl[0] = '{3, 0, 0, 0, 4, 0, 1};
        tbl[1] = '{1, 2, 0, 2, 6, 3, 3};
        tbl[2] = '{0, 3, 1, 0, 4, 0, 4};
        tbl[3] = '{2, 1, 0, 0, 6, 0, 2};
        tbl[4] = '{2, 1, 1, 1, 6, 4, 2};
        tbl[5] = '{0, 0, 0, 3, 1, 0, 1};

        rst          = 1'b1;
        i_cmd_valid  = 1'b0;
        i_cmd_ni     = '0;
        i_cmd_no     = '0;
        i_cmd_op     = '0;
        i_beat_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle();
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Command valid held through RUN: second copy accepted in the done cycle
        start_cmd(1, 0, 0, 1'b1);
        drive_beat();
        drive_beat();
        finish_cmd(2, 0, 1);
        arm_model(1, 0, 0);
        i_cmd_valid = 1'b0;
        drive_beat();
        drive_beat();
        finish_cmd(2, 0, 1);

        // Reset in the cycle after beat 2 of 4 drops the in-flight write
        start_cmd(3, 0, 1, 1'b0);
        drive_beat();
        drive_beat();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_dropped",   int'(o_nbout_wr_en), 0);
        chk("rst_last_dropped", int'(o_last),        0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check_idle();
        @(posedge clk); #1;
        run_vec(tbl[0]);

`ifdef NFU2_SEQ_PERF_EN
        start_cmd(3, 0, 0, 1'b0);
        drive_beat();
        idle_cycle();
        drive_beat();
        idle_cycle();
        drive_beat();
        drive_beat();
        finish_cmd(4, 2, 1);
        @(negedge clk);
        chk("perf_busy",  int'(o_perf_busy),  7);
        chk("perf_stall", int'(o_perf_stall), 2);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
